// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM encoding and queue entry type for the fetch sequencer.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef MEMI_SIZE
`define MEMI_SIZE 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef FETCH_QDEPTH
`define FETCH_QDEPTH 4
`endif
`ifndef FETCH_INIT_CYCLES
`define FETCH_INIT_CYCLES 1
`endif
`ifndef FETCH_S_INIT
`define FETCH_S_INIT 1'b0
`endif
`ifndef FETCH_S_RUN
`define FETCH_S_RUN 1'b1
`endif

package fetch_ctrl_pkg;

  localparam int AW = `MEMI_SIZE_LOG;
  localparam int MSIZE = `MEMI_SIZE;
  localparam int IL = `INST_LEN;
  localparam int FETCH_QDEPTH = `FETCH_QDEPTH;
  localparam int FETCH_INIT_CYCLES = `FETCH_INIT_CYCLES;

  typedef enum logic {
    S_INIT = `FETCH_S_INIT,
    S_RUN  = `FETCH_S_RUN
  } fstate_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IL-1:0] inst;
  } fq_entry_t;

  // memi size need not be a power of two
  function automatic logic [AW-1:0] pc_inc(
    input logic [AW-1:0] pc
  );
    if (pc == AW'(MSIZE - 1))
      return '0;
    return pc + AW'(1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// In-order fetch queue: {pc, inst} entries with enq/deq and priority flush.
// Callers gate enq on !full and deq on !empty.
import fetch_ctrl_pkg::*;

module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     enq_i,
  input  fq_entry_t                enq_data_i,
  input  logic                     deq_i,
  output logic                     full_o,
  output logic                     empty_o,
  output fq_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             enq, deq;

  assign enq = enq_i && !flush_i;
  assign deq = deq_i && !flush_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      if (enq && !deq) cnt_d = cnt_q + CW'(1);
      if (deq && !enq) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // payload needs no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= enq_data_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[head_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, init/run FSM and fire logic in front of memi.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall counters.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter int QDEPTH      = FETCH_QDEPTH,
  parameter int INIT_CYCLES = FETCH_INIT_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] memi_req_addr,
  input  logic [IL-1:0] memi_resp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IL-1:0] out_inst,
  output logic [AW-1:0] out_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt,
`endif
  output logic          busy
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int CW = $clog2(QDEPTH) + 1;

  fstate_e       state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          full, empty, fire, deq;
  fq_entry_t     enq_data, head;
  logic [CW-1:0] count;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    unique case (state_q)
      S_INIT: begin
        init_d = init_q + IW'(1);
        if (init_q == IW'(INIT_CYCLES - 1))
          state_d = S_RUN;
      end
      S_RUN: ;
      default: state_d = S_INIT;
    endcase
  end

  assign fire = (state_q == S_RUN) && fetch_en
             && !full && !redirect_valid;
  assign deq  = !empty && out_ready && !redirect_valid;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_valid: pc_d = redirect_pc;
      fire:           pc_d = pc_inc(pc_q);
      default:        pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      init_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      pc_q    <= pc_d;
    end
  end

  assign enq_data.pc   = pc_q;
  assign enq_data.inst = memi_resp_data;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .enq_i     (fire),
    .enq_data_i(enq_data),
    .deq_i     (deq),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head),
    .count_o   (count)
  );

  assign memi_req_addr = pc_q;
  assign out_valid     = (count != '0);
  assign out_inst      = head.inst;
  assign out_pc        = head.pc;
  assign busy          = (state_q == S_RUN);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_q, ps_q;
  logic        stall;

  assign stall = (state_q == S_RUN) && fetch_en
              && full && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q <= '0;
      ps_q <= '0;
    end else begin
      if (fire && !(&pf_q))  pf_q <= pf_q + 32'd1;
      if (stall && !(&ps_q)) ps_q <= ps_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = pf_q;
  assign perf_stall_cnt = ps_q;
`endif

endmodule
